// File: rtl/fbuf_pattern_writer.sv
// Framebuffer test-pattern source: walks every pixel of the scaled frame and
// writes grid, colour-bar, checkerboard or grey-ramp data over a valid/ready port.
module fbuf_pattern_writer #(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int SCALING_FACTOR  = 1,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int GRID_LOG2       = 5,
  parameter int CLEAR_ON_START  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [1:0]                 mode,
  output logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address,
  output logic [FBUF_DATA_WIDTH-1:0] pixel_fbuf_color,
  output logic                       pixel_fbuf_wr_en,
  input  logic                       pixel_fbuf_wr_ready,
  output logic                       pixel_fbuf_rst_req_n,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int W     = FRAME_WIDTH / SCALING_FACTOR;
  localparam int H     = FRAME_HEIGHT / SCALING_FACTOR;
  localparam int BAR_W = W / 8;
  localparam int XW    = $clog2(W + 1);
  localparam int YW    = $clog2(H + 1);
  localparam int BW    = $clog2(BAR_W + 1);
  localparam logic [31:0] CELL_MASK = 32'((1 << GRID_LOG2) - 1);
  localparam logic [31:0] CELL_HALF = 32'(1 << (GRID_LOG2 - 1));

  generate
    if (FBUF_DATA_WIDTH != 8 && FBUF_DATA_WIDTH != 16 && FBUF_DATA_WIDTH != 24) begin : g_bad_dw
      $error("fbuf_pattern_writer: FBUF_DATA_WIDTH must be 8, 16 or 24");
    end
    if (W * SCALING_FACTOR != FRAME_WIDTH || H * SCALING_FACTOR != FRAME_HEIGHT || (W % 8) != 0) begin : g_bad_geom
      $error("fbuf_pattern_writer: scaled width/height must divide exactly and width must be a multiple of 8");
    end
    if ((64'd1 << FBUF_ADDR_WIDTH) < 64'(W * H)) begin : g_bad_aw
      $error("fbuf_pattern_writer: FBUF_ADDR_WIDTH too small for the framebuffer");
    end
  endgenerate

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                     state_q, state_d;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic [BW-1:0]              bar_cnt_q, bar_cnt_d;
  logic [2:0]                 bar_idx_q, bar_idx_d;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]                 mode_q, mode_d;
  logic [FBUF_DATA_WIDTH-1:0] color_q, color_d;
  logic                       done_q, done_d;
  logic                       clr_n_q, clr_n_d;
  logic                       last_x, last_px;

  // Full-scale 8-bit channels are truncated to the MSBs that fit each field.
  function automatic logic [FBUF_DATA_WIDTH-1:0] pack_rgb(input logic [7:0] r,
                                                           input logic [7:0] g,
                                                           input logic [7:0] b);
    logic [23:0] p;
    case (FBUF_DATA_WIDTH)
      8:       p = {16'd0, r[7:5], g[7:5], b[7:6]};
      16:      p = {8'd0, r[7:3], g[7:2], b[7:3]};
      default: p = {r, g, b};
    endcase
    return p[FBUF_DATA_WIDTH-1:0];
  endfunction

  function automatic logic [FBUF_DATA_WIDTH-1:0] pattern(input logic [XW-1:0] x,
                                                          input logic [YW-1:0] y,
                                                          input logic [2:0]    bar,
                                                          input logic [1:0]    m);
    logic [31:0] xe, ye;
    logic [2:0]  c;
    logic [7:0]  r, g, b;
    xe = 32'(x);
    ye = 32'(y);
    c  = 3'b000;
    r  = 8'd0;
    g  = 8'd0;
    b  = 8'd0;
    case (m)
      2'd0: begin
        if ((xe & CELL_MASK) == CELL_HALF || (ye & CELL_MASK) == CELL_HALF) r = 8'hFF;
        else b = 8'hFF;
      end
      2'd1: begin
        case (bar)
          3'd0: c = 3'b111;
          3'd1: c = 3'b110;
          3'd2: c = 3'b011;
          3'd3: c = 3'b010;
          3'd4: c = 3'b101;
          3'd5: c = 3'b100;
          3'd6: c = 3'b001;
          default: c = 3'b000;
        endcase
        r = {8{c[2]}};
        g = {8{c[1]}};
        b = {8{c[0]}};
      end
      2'd2: begin
        r = {8{xe[GRID_LOG2] ^ ye[GRID_LOG2]}};
        g = r;
        b = r;
      end
      default: begin
        r = xe[7:0];
        g = xe[7:0];
        b = xe[7:0];
      end
    endcase
    return pack_rgb(r, g, b);
  endfunction

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    color_d   = color_q;
    done_d    = 1'b0;
    clr_n_d   = 1'b1;
    last_x    = (x_q == XW'(W - 1));
    last_px   = last_x && (y_q == YW'(H - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WRITE;
          mode_d    = mode;
          x_d       = '0;
          y_d       = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
          addr_d    = '0;
          clr_n_d   = (CLEAR_ON_START == 0);
        end
      end
      WRITE: begin
        if (pixel_fbuf_wr_ready) begin
          if (last_px) begin
            done_d    = 1'b1;
            x_d       = '0;
            y_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            addr_d    = '0;
            if (continuous) mode_d = mode;
            else            state_d = IDLE;
          end else begin
            addr_d = addr_q + FBUF_ADDR_WIDTH'(1);
            if (last_x) begin
              x_d       = '0;
              y_d       = y_q + YW'(1);
              bar_cnt_d = '0;
              bar_idx_d = '0;
            end else begin
              x_d = x_q + XW'(1);
              // Bar index advances from a sub-counter so no divider is needed.
              if (bar_cnt_q == BW'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
              end else begin
                bar_cnt_d = bar_cnt_q + BW'(1);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Colour is registered alongside the address it belongs to.
    if (state_d == WRITE) color_d = pattern(x_d, y_d, bar_idx_d, mode_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      addr_q    <= '0;
      mode_q    <= '0;
      color_q   <= '0;
      done_q    <= 1'b0;
      clr_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      color_q   <= color_d;
      done_q    <= done_d;
      clr_n_q   <= clr_n_d;
    end
  end

  assign pixel_fbuf_address   = addr_q;
  assign pixel_fbuf_color     = color_q;
  assign pixel_fbuf_wr_en     = (state_q == WRITE);
  assign busy                 = (state_q == WRITE);
  assign frame_done           = done_q;
  assign pixel_fbuf_rst_req_n = clr_n_q;

endmodule

// File: tb/tb_fbuf_pattern_writer.sv
// Scoreboard bench: two 16x4 instances (RGB332 with clear-on-start, RGB565 with 2x scaling).
module tb_fbuf_pattern_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, cont_a, ready_a, wr_en_a, rstreq_a, busy_a, done_a;
  logic [1:0]  mode_a;
  logic [7:0]  addr_a;
  logic [7:0]  color_a;
  logic        start_b, cont_b, ready_b, wr_en_b, rstreq_b, busy_b, done_b;
  logic [1:0]  mode_b;
  logic [7:0]  addr_b;
  logic [15:0] color_b;

  fbuf_pattern_writer #(
    .FRAME_WIDTH(16), .FRAME_HEIGHT(4), .SCALING_FACTOR(1), .FBUF_ADDR_WIDTH(8),
    .FBUF_DATA_WIDTH(8), .GRID_LOG2(2), .CLEAR_ON_START(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .mode(mode_a),
    .pixel_fbuf_address(addr_a), .pixel_fbuf_color(color_a), .pixel_fbuf_wr_en(wr_en_a),
    .pixel_fbuf_wr_ready(ready_a), .pixel_fbuf_rst_req_n(rstreq_a), .busy(busy_a),
    .frame_done(done_a)
  );

  fbuf_pattern_writer #(
    .FRAME_WIDTH(32), .FRAME_HEIGHT(8), .SCALING_FACTOR(2), .FBUF_ADDR_WIDTH(8),
    .FBUF_DATA_WIDTH(16), .GRID_LOG2(2), .CLEAR_ON_START(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b), .mode(mode_b),
    .pixel_fbuf_address(addr_b), .pixel_fbuf_color(color_b), .pixel_fbuf_wr_en(wr_en_b),
    .pixel_fbuf_wr_ready(ready_b), .pixel_fbuf_rst_req_n(rstreq_b), .busy(busy_b),
    .frame_done(done_b)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] color;
  } beat_t;

  beat_t       q_a[$];
  beat_t       q_b[$];
  beat_t       e_a, e_b;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  cap_a[64];
  logic [15:0] cap_b[64];
  int          done_cnt_a = 0, done_cnt_b = 0, rstreq_b_lows = 0;
  logic        last_a_prev = 1'b0, last_b_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-written reference tables for a 16x4 frame.
  function automatic logic [7:0] model_a(input int m, input int a);
    logic [7:0] bars[8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    int x = a % 16;
    int y = a / 16;
    case (m)
      0:       return ((x % 4) == 2 || (y % 4) == 2) ? 8'hE0 : 8'h03;
      1:       return bars[x / 2];
      2:       return (((x / 4) % 2) ^ ((y / 4) % 2)) != 0 ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] model_b(input int m, input int a);
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int x = a % 16;
    if (m == 1) return bars[x / 2];
    return 16'(((x >> 3) << 11) | ((x >> 2) << 5) | (x >> 3));
  endfunction

  task automatic push_frame_a(input int m);
    beat_t b;
    for (int a = 0; a < 64; a++) begin
      b.addr  = 8'(a);
      b.color = 24'(model_a(m, a));
      q_a.push_back(b);
    end
  endtask

  task automatic push_frame_b(input int m);
    beat_t b;
    for (int a = 0; a < 64; a++) begin
      b.addr  = 8'(a);
      b.color = 24'(model_b(m, a));
      q_b.push_back(b);
    end
  endtask

  // Monitors: pop and compare on every handshake, and tie frame_done to the last accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_a && ready_a) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_beat: unexpected beat addr=%0d color=0x%0h", addr_a, color_a);
        end else begin
          e_a = q_a.pop_front();
          if (addr_a !== e_a.addr || color_a !== e_a.color[7:0]) begin
            errors++;
            $display("FAIL a_beat: got addr=%0d color=0x%0h, expected addr=%0d color=0x%0h",
                     addr_a, color_a, e_a.addr, e_a.color[7:0]);
          end
        end
        cap_a[addr_a[5:0]] = color_a;
      end
      if (done_a) done_cnt_a++;
      if (done_a || last_a_prev) chk("a_frame_done_align", {31'd0, done_a}, {31'd0, last_a_prev});
      last_a_prev = wr_en_a && ready_a && (addr_a == 8'd63);
    end else begin
      last_a_prev = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_b && ready_b) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_beat: unexpected beat addr=%0d color=0x%0h", addr_b, color_b);
        end else begin
          e_b = q_b.pop_front();
          if (addr_b !== e_b.addr || color_b !== e_b.color[15:0]) begin
            errors++;
            $display("FAIL b_beat: got addr=%0d color=0x%0h, expected addr=%0d color=0x%0h",
                     addr_b, color_b, e_b.addr, e_b.color[15:0]);
          end
        end
        cap_b[addr_b[5:0]] = color_b;
      end
      if (done_b) done_cnt_b++;
      if (!rstreq_b) rstreq_b_lows++;
      if (done_b || last_b_prev) chk("b_frame_done_align", {31'd0, done_b}, {31'd0, last_b_prev});
      last_b_prev = wr_en_b && ready_b && (addr_b == 8'd63);
    end else begin
      last_b_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_done_b(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done_b) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; mode_a = 2'd0; ready_a = 1'b1;
    start_b = 1'b0; cont_b = 1'b0; mode_b = 2'd0; ready_b = 1'b1;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_color_a", 32'(color_a), 0);
    chk("rst_wr_en_a", 32'(wr_en_a), 0);
    chk("rst_rstreq_a", 32'(rstreq_a), 1);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_color_b", 32'(color_b), 0);
    chk("rst_wr_en_b", 32'(wr_en_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    tick(); rst_n = 1'b1;
    tick();

    // Grid frame with a 4-cycle stall on addr 5; mode change mid-frame must be ignored
    push_frame_a(0);
    mode_a = 2'd0; start_a = 1'b1;
    tick(); start_a = 1'b0; mode_a = 2'd3;
    @(negedge clk);
    chk("start_wr_en_a", 32'(wr_en_a), 1);
    chk("start_addr_a", 32'(addr_a), 0);
    chk("start_busy_a", 32'(busy_a), 1);
    chk("start_rstreq_low_a", 32'(rstreq_a), 0);
    tick();
    @(negedge clk);
    chk("rstreq_back_high_a", 32'(rstreq_a), 1);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      tick(); ready_a = 1'b0;
      @(negedge clk);
      chk("stall_addr_a", 32'(addr_a), 5);
      chk("stall_color_a", 32'(color_a), 32'h03);
      chk("stall_wr_en_a", 32'(wr_en_a), 1);
    end
    tick(); ready_a = 1'b1;
    wait_done_a("grid_frame_done");
    chk("single_wr_en_a", 32'(wr_en_a), 0);
    chk("single_busy_a", 32'(busy_a), 0);
    chk("grid_addr0", 32'(cap_a[0]), 32'h03);
    chk("grid_addr2", 32'(cap_a[2]), 32'hE0);
    chk("grid_addr32", 32'(cap_a[32]), 32'hE0);
    chk("grid_addr5", 32'(cap_a[5]), 32'h03);
    repeat (4) @(negedge clk);
    chk("grid_done_count", 32'(done_cnt_a), 1);

    // RGB565 colour bars and grey ramp on the scaled instance
    tick();
    push_frame_b(1); mode_b = 2'd1; start_b = 1'b1;
    tick(); start_b = 1'b0;
    wait_done_b("bars_frame_done");
    chk("bars_addr0", 32'(cap_b[0]), 32'hFFFF);
    chk("bars_addr1", 32'(cap_b[1]), 32'hFFFF);
    chk("bars_addr2", 32'(cap_b[2]), 32'hFFE0);
    chk("bars_addr10", 32'(cap_b[10]), 32'hF800);
    chk("bars_addr14", 32'(cap_b[14]), 32'h0000);
    chk("bars_addr15", 32'(cap_b[15]), 32'h0000);
    tick();
    push_frame_b(3); mode_b = 2'd3; start_b = 1'b1;
    tick(); start_b = 1'b0;
    wait_done_b("ramp_frame_done");
    chk("ramp_addr4", 32'(cap_b[4]), 32'h0020);
    chk("ramp_addr15", 32'(cap_b[15]), 32'h0861);

    // Continuous checkerboard: two frames, stray start and mode change in frame 2
    tick();
    push_frame_a(2); push_frame_a(2);
    mode_a = 2'd2; cont_a = 1'b1; start_a = 1'b1;
    tick(); start_a = 1'b0;
    wait_done_a("cont_frame1_done");
    chk("cont_no_bubble_wr_en", 32'(wr_en_a), 1);
    chk("cont_no_bubble_addr", 32'(addr_a), 0);
    repeat (10) tick();
    start_a = 1'b1; cont_a = 1'b0; mode_a = 2'd1;
    tick(); start_a = 1'b0;
    wait_done_a("cont_frame2_done");
    chk("cont_stop_wr_en", 32'(wr_en_a), 0);
    chk("cont_stop_busy", 32'(busy_a), 0);
    chk("cont_queue_empty", 32'(q_a.size()), 0);

    // Reset mid-frame at addr 20, then restart with clear request
    tick();
    push_frame_a(0); mode_a = 2'd0; start_a = 1'b1;
    tick(); start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (wr_en_a && addr_a == 8'd20) found = 1'b1;
    end
    chk("reach_addr20", {31'd0, found}, 1);
    tick(); rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_wr_en_a", 32'(wr_en_a), 0);
    chk("midrst_addr_a", 32'(addr_a), 0);
    chk("midrst_color_a", 32'(color_a), 0);
    chk("midrst_busy_a", 32'(busy_a), 0);
    q_a.delete();
    tick(); rst_n = 1'b1;
    tick();
    push_frame_a(1); mode_a = 2'd1; start_a = 1'b1;
    tick(); start_a = 1'b0;
    @(negedge clk);
    chk("restart_rstreq_low", 32'(rstreq_a), 0);
    chk("restart_wr_en", 32'(wr_en_a), 1);
    chk("restart_addr", 32'(addr_a), 0);
    tick();
    @(negedge clk);
    chk("restart_rstreq_high", 32'(rstreq_a), 1);
    wait_done_a("bars8_frame_done");
    chk("bars8_addr2", 32'(cap_a[2]), 32'hFC);
    chk("bars8_addr10", 32'(cap_a[10]), 32'hE0);

    repeat (3) tick();
    chk("final_queue_a", 32'(q_a.size()), 0);
    chk("final_queue_b", 32'(q_b.size()), 0);
    chk("final_done_cnt_a", 32'(done_cnt_a), 4);
    chk("final_done_cnt_b", 32'(done_cnt_b), 2);
    chk("b_rstreq_never_low", 32'(rstreq_b_lows), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
